// File: rtl/memory_player_pkg.sv
// rtl/memory_player_pkg.sv - shared types and constants for the memory sample player
//
// Purpose: player FSM state encoding and the fixed timing constants used by
//          memory_player and its testbench.
// Contents:
//   player_state_t : IDLE / RUN / DRAIN
//   MIN_DIV        : smallest effective rate divider (period = MIN_DIV+1 cycles)
//   FETCH_LATENCY  : cycles from a fetch (address registered) to sample emission
package memory_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } player_state_t;

  localparam int MIN_DIV       = 2;
  localparam int FETCH_LATENCY = 2;

endpackage

// File: rtl/memory_player_rate_counter.sv
// rtl/memory_player_rate_counter.sv - loadable down-counter producing the fetch tick
//
// Purpose: while enabled, ticks when the count is zero and reloads to i_reload,
//          otherwise decrements. Clear forces the count to zero so the first
//          enabled cycle ticks immediately.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : force count to 0 (has priority over i_en)
//   i_en           : count / tick enable
//   i_reload       : value loaded after each tick (period minus one)
//   o_tick         : high in the enabled cycle where the count is zero
module rate_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_reload,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);
  assign o_tick = i_en & w_zero;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      if (w_zero) begin
        r_count <= i_reload;
      end else begin
        r_count <= r_count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/memory_player.sv
// rtl/memory_player.sv - plays a region of a registered-read sample memory as a timed stream
//
// Purpose: fetches base+idx from the sample memory once every P = max(rate_div,2)+1
//          cycles, absorbs the memory's registered read, and emits each sample with
//          a one-cycle strobe two cycles after its fetch. Optional ping-pong looping
//          is built when MEMORY_PLAYER_PINGPONG_EN is defined (adds i_pingpong).
// Ports:
//   i_clk, i_reset    : clock, synchronous active-high reset
//   i_start, i_stop   : run request (idle only) / abort request (stop wins over start)
//   i_loop            : repeat region forever (latched at start)
//   i_pingpong        : reverse at each end when looping (macro builds only)
//   i_base_addr       : first region address (latched at start)
//   i_length          : sample count 1..2^ADDR_WIDTH, 0 ignored (latched at start)
//   i_rate_div        : sample period minus one, clamped to MIN_DIV (latched at start)
//   o_mem_addr        : registered memory read address
//   i_mem_data        : memory read data (one cycle after o_mem_addr)
//   o_sample          : last emitted sample, held between strobes
//   o_sample_valid    : one-cycle strobe for a new sample
//   o_busy            : high while not idle
//   o_done            : one-cycle pulse with the final sample of a non-looping run
module memory_player
  import memory_player_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_loop,
`ifdef MEMORY_PLAYER_PINGPONG_EN
  input  logic                  i_pingpong,
`endif
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  input  logic [DIV_WIDTH-1:0]  i_rate_div,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_sample_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH+1)'(1);

  player_state_t r_state, w_state_next;

  logic                     r_loop;
  logic [ADDR_WIDTH-1:0]    r_base;
  logic [ADDR_WIDTH:0]      r_len;
  logic [DIV_WIDTH-1:0]     r_period_m1;
  logic [ADDR_WIDTH:0]      r_idx, w_idx_next;
  logic                     r_dir, w_dir_next;   // 0 = ascending, 1 = descending
  logic [ADDR_WIDTH-1:0]    r_mem_addr;
  logic [FETCH_LATENCY-1:0] r_pipe;              // one bit per in-flight fetch stage
  logic [DATA_WIDTH-1:0]    r_sample;
  logic                     r_sample_valid;
  logic                     r_done;

  logic                     w_accept;
  logic                     w_abort;
  logic                     w_fetch;
  logic                     w_emit;
  logic                     w_pp_en;
  logic                     w_at_end;
  logic [ADDR_WIDTH:0]      w_len_m1;
  logic [ADDR_WIDTH-1:0]    w_fetch_addr;
  logic [DIV_WIDTH-1:0]     w_period_m1;

  assign w_accept     = (r_state == IDLE) & i_start & ~i_stop & (i_length != '0);
  assign w_abort      = (r_state != IDLE) & i_stop;
  assign w_len_m1     = r_len - IDX_ONE;
  assign w_at_end     = (r_idx == w_len_m1);
  assign w_fetch_addr = r_base + r_idx[ADDR_WIDTH-1:0];
  // A stopped cycle must not let a sample out, even if its fetch completed.
  assign w_emit       = r_pipe[FETCH_LATENCY-1] & ~w_abort;
  // Clamp keeps P >= 3 so a fetch always completes before the next one issues.
  assign w_period_m1  = (i_rate_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : i_rate_div;

`ifdef MEMORY_PLAYER_PINGPONG_EN
  logic r_pp;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pp <= 1'b0;
    end else if (w_accept) begin
      r_pp <= i_pingpong;
    end
  end
  assign w_pp_en = r_pp;
`else
  assign w_pp_en = 1'b0;
`endif

  // Counter is held at zero outside RUN so the first RUN cycle fetches at once.
  rate_counter #(
    .WIDTH (DIV_WIDTH)
  ) u_rate_counter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (r_state != RUN),
    .i_en     ((r_state == RUN) & ~i_stop),
    .i_reload (r_period_m1),
    .o_tick   (w_fetch)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_dir_next   = r_dir;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = RUN;
          w_idx_next   = '0;
          w_dir_next   = 1'b0;
        end
      end
      RUN: begin
        if (i_stop) begin
          w_state_next = IDLE;
        end else if (w_fetch) begin
          if (!r_dir) begin
            if (w_at_end) begin
              w_idx_next = '0;
              if (!r_loop) begin
                w_state_next = DRAIN;
              end else if (w_pp_en && (w_len_m1 != '0)) begin
                // Turn around without replaying the top endpoint.
                w_dir_next = 1'b1;
                w_idx_next = w_len_m1 - IDX_ONE;
              end
            end else begin
              w_idx_next = r_idx + IDX_ONE;
            end
          end else begin
            if (r_idx == '0) begin
              w_dir_next = 1'b0;
              w_idx_next = IDX_ONE;
            end else begin
              w_idx_next = r_idx - IDX_ONE;
            end
          end
        end
      end
      DRAIN: begin
        // Leave one cycle after done so busy covers the final sample.
        if (i_stop || r_done) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_loop         <= 1'b0;
      r_base         <= '0;
      r_len          <= '0;
      r_period_m1    <= '0;
      r_idx          <= '0;
      r_dir          <= 1'b0;
      r_mem_addr     <= '0;
      r_pipe         <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_loop      <= i_loop;
        r_base      <= i_base_addr;
        r_len       <= i_length;
        r_period_m1 <= w_period_m1;
      end
      r_idx <= w_idx_next;
      r_dir <= w_dir_next;
      if (w_fetch) begin
        r_mem_addr <= w_fetch_addr;
      end
      if (w_abort) begin
        r_pipe <= '0;
      end else begin
        r_pipe <= {r_pipe[FETCH_LATENCY-2:0], w_fetch};
      end
      r_sample_valid <= w_emit;
      if (w_emit) begin
        r_sample <= i_mem_data;
      end
      // Only the last fetch of a non-looping run can be in flight in DRAIN.
      r_done <= w_emit & (r_state == DRAIN);
    end
  end

  assign o_mem_addr     = r_mem_addr;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;
  assign o_busy         = (r_state != IDLE);
  assign o_done         = r_done;

endmodule

// File: tb/tb_memory_player.sv
// tb/tb_memory_player.sv - directed self-checking bench for memory_player
module tb_memory_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, loop_en;
`ifdef MEMORY_PLAYER_PINGPONG_EN
  logic        pingpong;
`endif
  logic [10:0] base_addr;
  logic [11:0] length;
  logic [15:0] rate_div;
  logic [10:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  sample;
  logic        sample_valid, busy, done;

  logic [7:0]  mem [2048];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  memory_player dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_stop         (stop),
    .i_loop         (loop_en),
`ifdef MEMORY_PLAYER_PINGPONG_EN
    .i_pingpong     (pingpong),
`endif
    .i_base_addr    (base_addr),
    .i_length       (length),
    .i_rate_div     (rate_div),
    .o_mem_addr     (mem_addr),
    .i_mem_data     (mem_data),
    .o_sample       (sample),
    .o_sample_valid (sample_valid),
    .o_busy         (busy),
    .o_done         (done)
  );

  typedef struct {
    logic [10:0] base;
    logic [11:0] len;
    logic [15:0] rd;
    int          period;
    logic [7:0]  first;
    logic [7:0]  last;
    int          done_off;
    int          inject_off;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic       exp_v;
    logic [7:0] exp_s;
    logic [10:0] exp_a;
    base_addr = v.base;
    length    = v.len;
    rate_div  = v.rd;
    loop_en   = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int off = 1; off <= v.done_off + 1; off++) begin
      if (off == v.inject_off) begin
        start     = 1'b1;
        base_addr = 11'h555;
        length    = 12'd5;
      end
      tick();
      start = 1'b0;
      exp_v = (off >= 3) && (((off - 3) % v.period) == 0) && (off <= v.done_off);
      check("sample_valid", int'(sample_valid), int'(exp_v));
      if (exp_v) begin
        exp_s = v.first + 8'((off - 3) / v.period);
        check("sample", int'(sample), int'(exp_s));
      end
      check("done", int'(done), int'(off == v.done_off));
      if (off == v.done_off) check("last_sample", int'(sample), int'(v.last));
      check("busy", int'(busy), int'(off <= v.done_off));
      if ((((off - 1) % v.period) == 0) && (off <= v.done_off - 2)) begin
        exp_a = v.base + 11'((off - 1) / v.period);
        check("mem_addr", int'(mem_addr), int'(exp_a));
      end
    end
  endtask

  initial begin
    int          cnt;
    logic [7:0]  held;
    for (int n = 0; n < 2048; n++) mem[n] = 8'(n);

    //          base    len    rd  P  first  last   done inject
    vecs[0] = '{11'h010, 12'd4, 16'd3, 4, 8'h10, 8'h13, 15, -1};
    vecs[1] = '{11'h7FE, 12'd4, 16'd3, 4, 8'hFE, 8'h01, 15, -1};
    vecs[2] = '{11'h020, 12'd3, 16'd0, 3, 8'h20, 8'h22,  9,  4};
    vecs[3] = '{11'h100, 12'd1, 16'd5, 6, 8'h00, 8'h00,  3, -1};
    vecs[4] = '{11'h005, 12'd2, 16'd2, 3, 8'h05, 8'h06,  6, -1};

    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
`ifdef MEMORY_PLAYER_PINGPONG_EN
    pingpong = 1'b0;
`endif
    base_addr = '0; length = '0; rate_div = '0;
    repeat (3) tick();
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // start together with stop while idle: stop wins
    base_addr = 11'h040; length = 12'd2; rate_div = 16'd3;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("startstop_valid", int'(sample_valid), 0);
    end

    // zero length is ignored
    length = 12'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("len0_busy", int'(busy), 0);
    tick();
    check("len0_busy2", int'(busy), 0);

    // looping run, stop with a fetch in flight
    base_addr = 11'h030; length = 12'd2; rate_div = 16'd3; loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 60 && cnt < 5; c++) begin
      tick();
      check("loop_done", int'(done), 0);
      if (sample_valid) begin
        check("loop_sample", int'(sample), int'(8'h30 + 8'(cnt % 2)));
        cnt++;
      end
    end
    check("loop_count", cnt, 5);
    held = 8'h30;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop_en = 1'b0;
    check("stop_busy", int'(busy), 0);
    check("stop_valid", int'(sample_valid), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_stop_valid", int'(sample_valid), 0);
      check("post_stop_done", int'(done), 0);
    end
    check("stop_sample_held", int'(sample), int'(held));

    // reset in the middle of a run
    base_addr = 11'h010; length = 12'd4; rate_div = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_mem_addr", int'(mem_addr), 0);
    check("midrst_sample", int'(sample), 0);
    check("midrst_valid", int'(sample_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    tick();
    run_vec(vecs[0]);

`ifdef MEMORY_PLAYER_PINGPONG_EN
    begin
      logic [7:0] pp_exp [7];
      pp_exp = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h00, 8'h01, 8'h02};
      base_addr = 11'h000; length = 12'd3; rate_div = 16'd2;
      loop_en = 1'b1; pingpong = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0;
      for (int c = 0; c < 60 && cnt < 7; c++) begin
        tick();
        if (sample_valid) begin
          check("pp_sample", int'(sample), int'(pp_exp[cnt]));
          cnt++;
        end
      end
      check("pp_count", cnt, 7);
      stop = 1'b1;
      tick();
      stop = 1'b0; loop_en = 1'b0; pingpong = 1'b0;
      check("pp_stop_busy", int'(busy), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
